// File: rtl/fifo_sync_thresh_if.sv
// ============================================================================
// Module   : fifo_sync_thresh_if
// Brief    : Bus bundle for fifo_sync_thresh. Optional o_HighWater with FIFO_WATERMARK_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface fifo_sync_thresh_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
);
  localparam int c_CntW = $clog2(DEPTH) + 1;

  logic              i_Flush;
  logic              i_WrEn;
  logic [WIDTH-1:0]  i_WrData;
  logic              i_RdEn;
  logic [WIDTH-1:0]  o_RdData;
  logic              o_Full;
  logic              o_Empty;
  logic              o_AlmostFull;
  logic              o_AlmostEmpty;
  logic [c_CntW-1:0] o_Count;
  logic              o_OverFlow;
  logic              o_UnderFlow;
`ifdef FIFO_WATERMARK_EN
  logic [c_CntW-1:0] o_HighWater;
`endif

  modport slave (
    input  i_Flush, i_WrEn, i_WrData, i_RdEn,
    output o_RdData, o_Full, o_Empty, o_AlmostFull, o_AlmostEmpty,
    output o_Count, o_OverFlow, o_UnderFlow
`ifdef FIFO_WATERMARK_EN
    , output o_HighWater
`endif
  );

  modport master (
    output i_Flush, i_WrEn, i_WrData, i_RdEn,
    input  o_RdData, o_Full, o_Empty, o_AlmostFull, o_AlmostEmpty,
    input  o_Count, o_OverFlow, o_UnderFlow
`ifdef FIFO_WATERMARK_EN
    , input o_HighWater
`endif
  );
endinterface

`default_nettype wire

// File: rtl/fifo_sync_thresh.sv
// ============================================================================
// Module   : fifo_sync_thresh
// Brief    : Single-clock FIFO, FWFT/standard read, thresholds, flush, error pulses.
//            Optional high-water mark when FIFO_WATERMARK_EN is defined.
// Revision : 1.0
// ============================================================================
`default_nettype none

module fifo_sync_thresh #(
  parameter     FWFT         = "TRUE",
  parameter int WIDTH        = 8,
  parameter int DEPTH        = 16,
  parameter int ALMOST_FULL  = DEPTH - 2,
  parameter int ALMOST_EMPTY = 2
) (
  input wire                i_Clk,
  input wire                i_Rst_n,
  fifo_sync_thresh_if.slave bus
);
  localparam int                c_PtrW        = $clog2(DEPTH);
  localparam int                c_CntW        = c_PtrW + 1;
  localparam logic [c_CntW-1:0] c_Depth       = c_CntW'(DEPTH);
  localparam logic [c_CntW-1:0] c_AlmostFull  = c_CntW'(ALMOST_FULL);
  localparam logic [c_CntW-1:0] c_AlmostEmpty = c_CntW'(ALMOST_EMPTY);
  localparam logic [c_CntW-1:0] c_One         = c_CntW'(1);

  logic [WIDTH-1:0]  r_Mem [DEPTH];
  logic [c_PtrW-1:0] r_WrPtr;
  logic [c_PtrW-1:0] r_RdPtr;
  logic [c_CntW-1:0] r_Count;
  logic [WIDTH-1:0]  r_RdData;
  logic              r_OverFlow;
  logic              r_UnderFlow;

  logic              w_Full;
  logic              w_Empty;
  logic              w_WrAcc;
  logic              w_RdAcc;
  logic [c_PtrW-1:0] w_RdPtrInc;
  logic [c_CntW-1:0] w_CountNext;
  logic [WIDTH-1:0]  w_RdDataNext;

  // Flush masks both requests so it never produces data movement or error pulses.
  assign w_Full     = (r_Count == c_Depth);
  assign w_Empty    = (r_Count == '0);
  assign w_WrAcc    = bus.i_WrEn && !w_Full  && !bus.i_Flush;
  assign w_RdAcc    = bus.i_RdEn && !w_Empty && !bus.i_Flush;
  assign w_RdPtrInc = r_RdPtr + 1'b1;

  always_comb begin
    w_CountNext = r_Count;
    case ({w_WrAcc, w_RdAcc})
      2'b10:   w_CountNext = r_Count + 1'b1;
      2'b01:   w_CountNext = r_Count - 1'b1;
      default: w_CountNext = r_Count;
    endcase
  end

  generate
    if (FWFT == "TRUE") begin : g_fwft
      // Keep the head entry registered; on the last-entry pop a same-cycle write becomes the head.
      always_comb begin
        w_RdDataNext = r_RdData;
        if (w_RdAcc) begin
          if (r_Count > c_One)
            w_RdDataNext = r_Mem[w_RdPtrInc];
          else if (w_WrAcc)
            w_RdDataNext = bus.i_WrData;
        end else if (w_Empty && w_WrAcc) begin
          w_RdDataNext = bus.i_WrData;
        end
      end
    end else begin : g_std
      always_comb begin
        w_RdDataNext = r_RdData;
        if (w_RdAcc)
          w_RdDataNext = r_Mem[r_RdPtr];
      end
    end
  endgenerate

  always_ff @(posedge i_Clk) begin
    if (w_WrAcc)
      r_Mem[r_WrPtr] <= bus.i_WrData;
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      r_WrPtr     <= '0;
      r_RdPtr     <= '0;
      r_Count     <= '0;
      r_OverFlow  <= 1'b0;
      r_UnderFlow <= 1'b0;
    end else if (bus.i_Flush) begin
      r_WrPtr     <= '0;
      r_RdPtr     <= '0;
      r_Count     <= '0;
      r_OverFlow  <= 1'b0;
      r_UnderFlow <= 1'b0;
    end else begin
      if (w_WrAcc)
        r_WrPtr <= r_WrPtr + 1'b1;
      if (w_RdAcc)
        r_RdPtr <= w_RdPtrInc;
      r_Count     <= w_CountNext;
      r_OverFlow  <= bus.i_WrEn && w_Full;
      r_UnderFlow <= bus.i_RdEn && w_Empty;
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n)
      r_RdData <= '0;
    else
      r_RdData <= w_RdDataNext;
  end

`ifdef FIFO_WATERMARK_EN
  logic [c_CntW-1:0] r_HighWater;

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n)
      r_HighWater <= '0;
    else if (bus.i_Flush)
      r_HighWater <= '0;
    else if (w_CountNext > r_HighWater)
      r_HighWater <= w_CountNext;
  end

  assign bus.o_HighWater = r_HighWater;
`endif

  assign bus.o_RdData      = r_RdData;
  assign bus.o_Full        = w_Full;
  assign bus.o_Empty       = w_Empty;
  assign bus.o_AlmostFull  = (r_Count >= c_AlmostFull);
  assign bus.o_AlmostEmpty = (r_Count <= c_AlmostEmpty);
  assign bus.o_Count       = r_Count;
  assign bus.o_OverFlow    = r_OverFlow;
  assign bus.o_UnderFlow   = r_UnderFlow;

endmodule

`default_nettype wire

// File: tb/tb_fifo_sync_thresh.sv
// ============================================================================
// Module   : tb_fifo_sync_thresh
// Brief    : Bench for fifo_sync_thresh, FWFT and standard instances side by side.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_fifo_sync_thresh;
  localparam int WIDTH  = 8;
  localparam int DEPTH  = 4;
  localparam int AFULL  = 3;
  localparam int AEMPTY = 1;

  logic clk  = 1'b0;
  logic rstN = 1'b1;
  int   nTests = 0;
  int   nFail  = 0;

  always #5 clk = ~clk;

  fifo_sync_thresh_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) busF ();
  fifo_sync_thresh_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) busS ();

  fifo_sync_thresh #(
    .FWFT("TRUE"), .WIDTH(WIDTH), .DEPTH(DEPTH),
    .ALMOST_FULL(AFULL), .ALMOST_EMPTY(AEMPTY)
  ) dutF (
    .i_Clk(clk), .i_Rst_n(rstN), .bus(busF)
  );

  fifo_sync_thresh #(
    .FWFT("FALSE"), .WIDTH(WIDTH), .DEPTH(DEPTH),
    .ALMOST_FULL(AFULL), .ALMOST_EMPTY(AEMPTY)
  ) dutS (
    .i_Clk(clk), .i_Rst_n(rstN), .bus(busS)
  );

  typedef struct {
    logic       flush;
    logic       wr;
    logic [7:0] data;
    logic       rd;
    int         cnt;
    logic       ovf;
    logic       udf;
  } vec_t;

  vec_t       vecs[$];
  logic [7:0] q[$];
  logic [7:0] stdExp;
  int         hwExp;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic fl, input logic wr, input logic [7:0] d, input logic rd);
    busF.i_Flush = fl; busF.i_WrEn = wr; busF.i_WrData = d; busF.i_RdEn = rd;
    busS.i_Flush = fl; busS.i_WrEn = wr; busS.i_WrData = d; busS.i_RdEn = rd;
  endtask

  task automatic addVec(input logic fl, input logic wr, input logic [7:0] d, input logic rd,
                        input int c, input logic o, input logic u);
    vecs.push_back('{fl, wr, d, rd, c, o, u});
  endtask

  // Drive one cycle, advance the reference queue, then compare after the edge.
  task automatic step(input logic fl, input logic wr, input logic [7:0] d, input logic rd,
                      input int expCnt, input logic expOvf, input logic expUdf, input string tag);
    bit wrAcc;
    bit rdAcc;
    @(negedge clk);
    drive(fl, wr, d, rd);
    wrAcc = wr && !fl && (q.size() < DEPTH);
    rdAcc = rd && !fl && (q.size() > 0);
    if (fl) begin
      q.delete();
      hwExp = 0;
    end
    if (rdAcc) stdExp = q.pop_front();
    if (wrAcc) q.push_back(d);
    if (q.size() > hwExp) hwExp = q.size();
    @(posedge clk);
    #1;
    chk({tag, " countF"},  32'(busF.o_Count), 32'(expCnt));
    chk({tag, " countS"},  32'(busS.o_Count), 32'(expCnt));
    chk({tag, " full"},    32'(busF.o_Full), 32'(expCnt == DEPTH));
    chk({tag, " empty"},   32'(busF.o_Empty), 32'(expCnt == 0));
    chk({tag, " afull"},   32'(busF.o_AlmostFull), 32'(expCnt >= AFULL));
    chk({tag, " aempty"},  32'(busF.o_AlmostEmpty), 32'(expCnt <= AEMPTY));
    chk({tag, " ovf"},     32'(busF.o_OverFlow), 32'(expOvf));
    chk({tag, " udf"},     32'(busS.o_UnderFlow), 32'(expUdf));
    if (q.size() > 0)
      chk({tag, " fwftData"}, 32'(busF.o_RdData), 32'(q[0]));
    chk({tag, " stdData"}, 32'(busS.o_RdData), 32'(stdExp));
`ifdef FIFO_WATERMARK_EN
    chk({tag, " highWater"}, 32'(busF.o_HighWater), 32'(hwExp));
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    stdExp = 8'h00;
    hwExp  = 0;
    #1 rstN = 1'b0;
    #11;
    chk("reset count",  32'(busF.o_Count), 32'd0);
    chk("reset empty",  32'(busF.o_Empty), 32'd1);
    chk("reset full",   32'(busF.o_Full), 32'd0);
    chk("reset aempty", 32'(busF.o_AlmostEmpty), 32'd1);
    chk("reset afull",  32'(busF.o_AlmostFull), 32'd0);
    chk("reset dataF",  32'(busF.o_RdData), 32'd0);
    chk("reset dataS",  32'(busS.o_RdData), 32'd0);
    chk("reset pulses", 32'({busF.o_OverFlow, busF.o_UnderFlow}), 32'd0);
    @(negedge clk);
    rstN = 1'b1;

    // flush, wr, data, rd, expected count, overflow, underflow
    addVec(0, 1, 8'hA0, 0, 1, 0, 0);
    addVec(0, 1, 8'hA1, 0, 2, 0, 0);
    addVec(0, 1, 8'hA2, 0, 3, 0, 0);
    addVec(0, 1, 8'hA3, 0, 4, 0, 0);
    addVec(0, 1, 8'hFF, 0, 4, 1, 0);
    addVec(0, 0, 8'h00, 0, 4, 0, 0);
    addVec(0, 1, 8'hEE, 1, 3, 1, 0);
    addVec(0, 0, 8'h00, 1, 2, 0, 0);
    addVec(0, 0, 8'h00, 0, 2, 0, 0);
    addVec(0, 0, 8'h00, 1, 1, 0, 0);
    addVec(0, 0, 8'h00, 1, 0, 0, 0);
    addVec(0, 0, 8'h00, 1, 0, 0, 1);
    addVec(0, 0, 8'h00, 0, 0, 0, 0);
    addVec(0, 1, 8'hC0, 0, 1, 0, 0);
    addVec(0, 1, 8'hC1, 0, 2, 0, 0);
    for (int i = 0; i < 7; i++)
      addVec(0, 1, 8'hB0 + 8'(i), 1, 2, 0, 0);
    addVec(0, 0, 8'h00, 1, 1, 0, 0);
    addVec(0, 0, 8'h00, 1, 0, 0, 0);

    foreach (vecs[i])
      step(vecs[i].flush, vecs[i].wr, vecs[i].data, vecs[i].rd,
           vecs[i].cnt, vecs[i].ovf, vecs[i].udf, $sformatf("vec%0d", i));

    // Reset asserted between edges discards contents immediately.
    step(0, 1, 8'h11, 0, 1, 0, 0, "preRst0");
    step(0, 1, 8'h22, 0, 2, 0, 0, "preRst1");
    @(negedge clk);
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    #2 rstN = 1'b0;
    #1;
    q.delete();
    stdExp = 8'h00;
    hwExp  = 0;
    chk("midRst count", 32'(busF.o_Count), 32'd0);
    chk("midRst empty", 32'(busS.o_Empty), 32'd1);
    chk("midRst dataF", 32'(busF.o_RdData), 32'd0);
    @(negedge clk);
    rstN = 1'b1;
    step(0, 1, 8'hF0, 0, 1, 0, 0, "postRst0");
    step(0, 1, 8'hF1, 0, 2, 0, 0, "postRst1");
    step(0, 1, 8'hF2, 0, 3, 0, 0, "postRst2");

    // Flush with concurrent requests: cleared, no pulses, old data never returns.
    step(1, 1, 8'hD3, 1, 0, 0, 0, "flush");
    step(0, 0, 8'h00, 1, 0, 0, 1, "flushUdf");
    step(0, 1, 8'hE0, 0, 1, 0, 0, "postFlushWr");
    step(0, 0, 8'h00, 1, 0, 0, 0, "postFlushRd");

    @(negedge clk);
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule

`default_nettype wire
